// File: rtl/a1339_spi_scheduler_if.sv
// Requester/engine bundle around the A1339 SPI scheduler.
// slave: the scheduler itself; master: the requesters and the SPI engine.
interface a1339_spi_scheduler_if #(
  parameter int NUM_CLIENTS  = 3,
  parameter int DATA_WIDTH   = 20,
  parameter int SENSOR_IDX_W = 8
);
  logic [NUM_CLIENTS-1:0]                   req_i;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]   req_data_i;
  logic [NUM_CLIENTS-1:0][SENSOR_IDX_W-1:0] req_sensor_i;
  logic [NUM_CLIENTS-1:0]                   grant_o;
  logic [NUM_CLIENTS-1:0]                   done_o;
  logic [DATA_WIDTH-1:0]                    rsp_data_o;
  logic                                     rsp_error_o;
  logic                                     busy_o;
  logic                                     eng_wren_o;
  logic [DATA_WIDTH-1:0]                    eng_data_o;
  logic [SENSOR_IDX_W-1:0]                  eng_sensor_o;
  logic                                     eng_do_valid_i;
  logic [DATA_WIDTH-1:0]                    eng_data_i;

  modport slave (
    input  req_i, req_data_i, req_sensor_i, eng_do_valid_i, eng_data_i,
    output grant_o, done_o, rsp_data_o, rsp_error_o, busy_o,
           eng_wren_o, eng_data_o, eng_sensor_o
  );

  modport master (
    output req_i, req_data_i, req_sensor_i, eng_do_valid_i, eng_data_i,
    input  grant_o, done_o, rsp_data_o, rsp_error_o, busy_o,
           eng_wren_o, eng_data_o, eng_sensor_o
  );
endinterface

// File: rtl/a1339_spi_scheduler.sv
// Round-robin sharing of one A1339 SPI engine: one frame per grant, response
// routed to the winner, fixed inter-frame gap, timeout on a hung engine.
module a1339_spi_scheduler #(
  parameter int NUM_CLIENTS    = 3,
  parameter int DATA_WIDTH     = 20,
  parameter int SENSOR_IDX_W   = 8,
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                   clock,
  input logic                   reset_n,
  a1339_spi_scheduler_if.slave  bus
);
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, GAP} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [TO_W-1:0]         r_to_cnt;
  logic [GAP_W-1:0]        r_gap_cnt;
  logic [NUM_CLIENTS-1:0]  r_grant;
  logic [NUM_CLIENTS-1:0]  r_done;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_rsp_error;
  logic                    r_busy;
  logic                    r_wren;
  logic [DATA_WIDTH-1:0]   r_eng_data;
  logic [SENSOR_IDX_W-1:0] r_eng_sensor;

  logic                    w_found;
  logic [IDX_W-1:0]        w_win;
  logic [IDX_W-1:0]        w_next_ptr;
  logic                    w_finish;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!w_found && bus.req_i[(int'(r_rr_ptr) + i) % NUM_CLIENTS]) begin
        w_found = 1'b1;
        w_win   = IDX_W'((int'(r_rr_ptr) + i) % NUM_CLIENTS);
      end
    end
  end

  assign w_next_ptr = IDX_W'((int'(w_win) + 1) % NUM_CLIENTS);
  // A response on the last timeout cycle still counts as a success.
  assign w_finish   = bus.eng_do_valid_i || (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
      r_busy       <= 1'b0;
      r_wren       <= 1'b0;
      r_eng_data   <= '0;
      r_eng_sensor <= '0;
    end else begin
      r_wren <= 1'b0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= NUM_CLIENTS'(1) << w_win;
            r_wren       <= 1'b1;
            r_eng_data   <= bus.req_data_i[w_win];
            r_eng_sensor <= bus.req_sensor_i[w_win];
            r_rr_ptr     <= w_next_ptr;
            r_to_cnt     <= '0;
            r_busy       <= 1'b1;
            r_state      <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (w_finish) begin
            r_rsp_data  <= bus.eng_do_valid_i ? bus.eng_data_i : '0;
            r_rsp_error <= !bus.eng_do_valid_i;
            r_done      <= r_grant;
            r_grant     <= '0;
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= GAP_W'(GAP_CYCLES);
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt <= GAP_W'(1)) begin
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant_o      = r_grant;
  assign bus.done_o       = r_done;
  assign bus.rsp_data_o   = r_rsp_data;
  assign bus.rsp_error_o  = r_rsp_error;
  assign bus.busy_o       = r_busy;
  assign bus.eng_wren_o   = r_wren;
  assign bus.eng_data_o   = r_eng_data;
  assign bus.eng_sensor_o = r_eng_sensor;
endmodule

// File: tb/tb_a1339_spi_scheduler.sv
// Bench for a1339_spi_scheduler: engine model plus done-pulse scoreboard on the
// default instance, and a short-timeout instance for the hung-engine case.
module tb_a1339_spi_scheduler;
  localparam int N  = 3;
  localparam int DW = 20;
  localparam int SW = 8;
  localparam logic [DW-1:0] KEY = 20'h2C001 ^ 20'h12345;

  typedef struct {
    logic [N-1:0]  grant;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  a1339_spi_scheduler_if #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .SENSOR_IDX_W(SW)) ifc ();
  a1339_spi_scheduler_if #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .SENSOR_IDX_W(SW)) ifc2 ();

  a1339_spi_scheduler #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .SENSOR_IDX_W(SW),
                        .GAP_CYCLES(50), .TIMEOUT_CYCLES(4096))
    dut (.clock(clock), .reset_n(reset_n), .bus(ifc));

  a1339_spi_scheduler #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .SENSOR_IDX_W(SW),
                        .GAP_CYCLES(50), .TIMEOUT_CYCLES(16))
    dut2 (.clock(clock), .reset_n(reset_n), .bus(ifc2));

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  int            wren_cyc[$];
  int            eng_lat  = 10;
  int            resp_cd  = 0;
  int            spur_req = 0;
  int            spur_ack = 0;
  logic [DW-1:0] pend;

  always @(posedge clock) cyc <= cyc + 1;

  // Engine model: answers each strobe with (frame ^ KEY) eng_lat cycles later.
  always @(negedge clock) begin
    ifc.eng_do_valid_i = 1'b0;
    ifc.eng_data_i     = '0;
    if (!reset_n) begin
      resp_cd = 0;
    end else begin
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          ifc.eng_do_valid_i = 1'b1;
          ifc.eng_data_i     = pend ^ KEY;
        end
      end
      if (spur_req != spur_ack) begin
        spur_ack           = spur_req;
        ifc.eng_do_valid_i = 1'b1;
        ifc.eng_data_i     = 20'hFFFFF;
      end
      if (ifc.eng_wren_o) begin
        wren_cyc.push_back(cyc);
        pend = ifc.eng_data_o;
        if (eng_lat > 0) resp_cd = eng_lat;
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && (|ifc.done_o)) begin
      done_cnt++;
      last_done_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: done_o=%b rsp=%h with nothing expected", ifc.done_o, ifc.rsp_data_o);
      end else begin
        mon_e = sb.pop_front();
        if (ifc.done_o !== mon_e.grant || ifc.rsp_data_o !== mon_e.data ||
            ifc.rsp_error_o !== mon_e.err || ifc.grant_o !== '0) begin
          n_fail++;
          $display("FAIL sb_done: got done=%b data=%h err=%b grant=%b, expected done=%b data=%h err=%b grant=000",
                   ifc.done_o, ifc.rsp_data_o, ifc.rsp_error_o, ifc.grant_o, mon_e.grant, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int k = 0;
    while (ifc.busy_o !== 1'b0 && k < 300) begin @(negedge clock); k++; end
    n_checks++;
    if (k >= 300) begin n_fail++; $display("FAIL %s_idle_timeout: busy_o=%b, expected 0", tag, ifc.busy_o); end
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int k = 0;
    while (done_cnt < target && k < bound) begin @(negedge clock); k++; end
    n_checks++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done count %0d, expected %0d", tag, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({ifc.grant_o, ifc.done_o, ifc.rsp_data_o, ifc.rsp_error_o, ifc.busy_o,
         ifc.eng_wren_o, ifc.eng_data_o, ifc.eng_sensor_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b done=%b rsp=%h busy=%b wren=%b, expected all 0",
               ifc.grant_o, ifc.done_o, ifc.rsp_data_o, ifc.busy_o, ifc.eng_wren_o);
    end
    n_checks++;
    if ({ifc2.grant_o, ifc2.done_o, ifc2.rsp_data_o, ifc2.rsp_error_o, ifc2.busy_o,
         ifc2.eng_wren_o, ifc2.eng_data_o, ifc2.eng_sensor_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: grant=%b busy=%b wren=%b, expected all 0", ifc2.grant_o, ifc2.busy_o, ifc2.eng_wren_o);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 0, 1};
    int n0, w0, c0;
    wait_idle("rr");
    eng_lat = 10;
    for (int k = 0; k < N; k++) begin
      ifc.req_data_i[k]   = DW'(20'h10000 + k * 20'h00111);
      ifc.req_sensor_i[k] = SW'(k + 5);
    end
    for (int k = 0; k < 5; k++)
      sb.push_back('{N'(1) << order[k], ifc.req_data_i[order[k]] ^ KEY, 1'b0});
    n0 = done_cnt; w0 = wren_cyc.size(); c0 = cyc;
    ifc.req_i = 3'b111;
    wait_done(n0 + 5, 400, "rr");
    ifc.req_i = '0;
    n_checks++;
    if (wren_cyc.size() < w0 + 5) begin
      n_fail++;
      $display("FAIL rr_wren_count: saw %0d strobes, expected 5", wren_cyc.size() - w0);
    end else begin
      if (wren_cyc[w0] != c0 + 1) begin
        n_fail++;
        $display("FAIL rr_first_latency: strobe at %0d, expected %0d", wren_cyc[w0], c0 + 1);
      end
      for (int i = 1; i < 5; i++) begin
        n_checks++;
        if (wren_cyc[w0 + i] - wren_cyc[w0 + i - 1] != 62) begin
          n_fail++;
          $display("FAIL rr_spacing: gap %0d, expected 62", wren_cyc[w0 + i] - wren_cyc[w0 + i - 1]);
        end
      end
    end
  endtask

  task automatic test_single();
    int n0, c0;
    wait_idle("single");
    eng_lat = 40;
    ifc.req_data_i[0]   = 20'h2C001;
    ifc.req_sensor_i[0] = 8'd2;
    sb.push_back('{3'b001, 20'h12345, 1'b0});
    n0 = done_cnt; c0 = cyc;
    ifc.req_i = 3'b001;
    @(negedge clock);
    n_checks++;
    if (ifc.eng_wren_o !== 1'b1 || ifc.grant_o !== 3'b001) begin
      n_fail++;
      $display("FAIL single_strobe: wren=%b grant=%b, expected 1 / 001", ifc.eng_wren_o, ifc.grant_o);
    end
    n_checks++;
    if (ifc.eng_sensor_o !== 8'd2 || ifc.eng_data_o !== 20'h2C001) begin
      n_fail++;
      $display("FAIL single_frame: sensor=%0d data=%h, expected 2 / 2c001", ifc.eng_sensor_o, ifc.eng_data_o);
    end
    @(negedge clock);
    n_checks++;
    if (ifc.eng_wren_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_strobe_width: wren=%b on second cycle, expected 0", ifc.eng_wren_o);
    end
    wait_done(n0 + 1, 100, "single");
    ifc.req_i = '0;
    n_checks++;
    if (last_done_cyc - (c0 + 1) != 41) begin
      n_fail++;
      $display("FAIL single_done_time: done %0d cycles after strobe, expected 41", last_done_cyc - (c0 + 1));
    end
  endtask

  task automatic test_spurious();
    int n0;
    wait_idle("spur");
    n0 = done_cnt;
    spur_req++;
    repeat (3) @(negedge clock);
    n_checks++;
    if (done_cnt != n0 || ifc.busy_o !== 1'b0 || ifc.rsp_data_o !== 20'h12345) begin
      n_fail++;
      $display("FAIL spur_idle: dones=%0d busy=%b rsp=%h, expected %0d / 0 / 12345", done_cnt, ifc.busy_o, ifc.rsp_data_o, n0);
    end
    eng_lat = 5;
    ifc.req_data_i[2]   = 20'h0BEEF;
    ifc.req_sensor_i[2] = 8'd9;
    sb.push_back('{3'b100, 20'h0BEEF ^ KEY, 1'b0});
    ifc.req_i = 3'b100;
    wait_done(n0 + 1, 50, "spur");
    ifc.req_i = '0;
    @(negedge clock);
    spur_req++;
    repeat (3) @(negedge clock);
    n_checks++;
    if (done_cnt != n0 + 1 || ifc.busy_o !== 1'b1 || ifc.rsp_data_o !== (20'h0BEEF ^ KEY)) begin
      n_fail++;
      $display("FAIL spur_gap: dones=%0d busy=%b rsp=%h, expected %0d / 1 / %h",
               done_cnt, ifc.busy_o, ifc.rsp_data_o, n0 + 1, 20'h0BEEF ^ KEY);
    end
  endtask

  task automatic test_drop_and_hold();
    int n0;
    wait_idle("drop");
    eng_lat = 20;
    ifc.req_data_i[1] = 20'h5A5A5;
    sb.push_back('{3'b010, 20'h5A5A5 ^ KEY, 1'b0});
    n0 = done_cnt;
    ifc.req_i = 3'b010;
    @(negedge clock);
    @(negedge clock);
    ifc.req_i = '0;
    ifc.req_data_i[1] = 20'h00000;
    wait_done(n0 + 1, 60, "drop");
    wait_idle("hold");
    ifc.req_data_i[0] = 20'h33333;
    sb.push_back('{3'b001, 20'h33333 ^ KEY, 1'b0});
    ifc.req_i = 3'b001;
    repeat (4) @(negedge clock);
    ifc.req_data_i[0] = 20'h44444;
    repeat (2) @(negedge clock);
    n_checks++;
    if (ifc.eng_data_o !== 20'h33333) begin
      n_fail++;
      $display("FAIL hold_eng_data: eng_data_o=%h, expected 33333", ifc.eng_data_o);
    end
    wait_done(n0 + 2, 60, "hold");
    ifc.req_i = '0;
  endtask

  task automatic test_reset_mid();
    int n0, w0, c0;
    wait_idle("rstmid");
    eng_lat = 30;
    ifc.req_data_i[1] = 20'h6C6C6;
    ifc.req_i = 3'b010;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ifc.grant_o, ifc.done_o, ifc.rsp_data_o, ifc.rsp_error_o, ifc.busy_o,
         ifc.eng_wren_o, ifc.eng_data_o, ifc.eng_sensor_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: grant=%b rsp=%h busy=%b data=%h, expected all 0",
               ifc.grant_o, ifc.rsp_data_o, ifc.busy_o, ifc.eng_data_o);
    end
    ifc.req_data_i[0] = 20'h0F0F0;
    ifc.req_data_i[2] = 20'h7E7E7;
    ifc.req_i = 3'b101;
    repeat (3) @(negedge clock);
    sb.push_back('{3'b001, 20'h0F0F0 ^ KEY, 1'b0});
    sb.push_back('{3'b100, 20'h7E7E7 ^ KEY, 1'b0});
    n0 = done_cnt; w0 = wren_cyc.size(); c0 = cyc;
    reset_n = 1'b1;
    wait_done(n0 + 1, 60, "rstmid0");
    ifc.req_i = 3'b100;
    wait_done(n0 + 2, 120, "rstmid2");
    ifc.req_i = '0;
    n_checks++;
    if (wren_cyc.size() <= w0 || wren_cyc[w0] != c0 + 1) begin
      n_fail++;
      $display("FAIL rstmid_first_strobe: %0d strobes after release, expected first at %0d", wren_cyc.size() - w0, c0 + 1);
    end
  endtask

  task automatic test_timeout();
    int k, t0;
    ifc2.req_data_i[2] = 20'hABCDE;
    ifc2.req_i = 3'b100;
    k = 0;
    while (ifc2.eng_wren_o !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    repeat (3) @(negedge clock);
    ifc2.eng_do_valid_i = 1'b1;
    ifc2.eng_data_i     = 20'hABCDE;
    @(negedge clock);
    ifc2.eng_do_valid_i = 1'b0;
    ifc2.req_i = '0;
    n_checks++;
    if (ifc2.done_o !== 3'b100 || ifc2.rsp_data_o !== 20'hABCDE || ifc2.rsp_error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_preload: done=%b rsp=%h err=%b, expected 100 / abcde / 0", ifc2.done_o, ifc2.rsp_data_o, ifc2.rsp_error_o);
    end
    k = 0;
    while (ifc2.busy_o !== 1'b0 && k < 100) begin @(negedge clock); k++; end
    ifc2.req_data_i[0] = 20'h11111;
    ifc2.req_data_i[1] = 20'h22222;
    ifc2.req_i = 3'b011;
    k = 0;
    while (ifc2.eng_wren_o !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    t0 = cyc;
    n_checks++;
    if (ifc2.grant_o !== 3'b001) begin
      n_fail++;
      $display("FAIL to_grant: grant=%b, expected 001", ifc2.grant_o);
    end
    k = 0;
    while (ifc2.done_o === '0 && k < 40) begin @(negedge clock); k++; end
    n_checks++;
    if (cyc - t0 != 16 || ifc2.done_o !== 3'b001 || ifc2.rsp_error_o !== 1'b1 || ifc2.rsp_data_o !== '0) begin
      n_fail++;
      $display("FAIL to_done: after %0d cycles done=%b err=%b rsp=%h, expected 16 / 001 / 1 / 00000",
               cyc - t0, ifc2.done_o, ifc2.rsp_error_o, ifc2.rsp_data_o);
    end
    ifc2.req_i = 3'b010;
    @(negedge clock);
    k = 0;
    while (ifc2.eng_wren_o !== 1'b1 && k < 100) begin @(negedge clock); k++; end
    n_checks++;
    if (cyc - t0 != 67 || ifc2.grant_o !== 3'b010) begin
      n_fail++;
      $display("FAIL to_next: strobe %0d cycles after previous grant=%b, expected 67 / 010", cyc - t0, ifc2.grant_o);
    end
    ifc2.req_i = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    ifc.req_i = '0;  ifc.req_data_i = '0;  ifc.req_sensor_i = '0;
    ifc2.req_i = '0; ifc2.req_data_i = '0; ifc2.req_sensor_i = '0;
    ifc2.eng_do_valid_i = 1'b0; ifc2.eng_data_i = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_spurious();
    test_drop_and_hold();
    test_reset_mid();
    test_timeout();
    repeat (5) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected completions never seen, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/a1339_spi_scheduler.md
Name: a1339_spi_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one 20-bit A1339 SPI transaction engine (the spi_master instance) between several requesters, e.g. the angle/turns poller, an EEPROM config writer and a diagnostics reader.
- Issues one frame per grant and routes the response back to the winner.
- Enforces the mandatory inter-frame gap the A1339 needs between frames.
- Recovers from a hung engine via a response timeout.

Parameters:
- NUM_CLIENTS, 3: number of requesters (1..8).
- DATA_WIDTH, 20: SPI frame width.
- SENSOR_IDX_W, 8: width of the sensor (slave-select) index.
- GAP_CYCLES, 50: idle clocks inserted after every completed or timed-out frame.
- TIMEOUT_CYCLES, 4096: max clocks to wait for eng_do_valid_i after issue (>=2).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_i  in  NUM_CLIENTS  per-client request level
- req_data_i  in  NUM_CLIENTS*DATA_WIDTH  per-client frame to send; client k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_sensor_i  in  NUM_CLIENTS*SENSOR_IDX_W  per-client target sensor index
- grant_o  out  NUM_CLIENTS  one-hot, high while that client's frame is in flight
- done_o  out  NUM_CLIENTS  one-cycle completion pulse to the winner
- rsp_data_o  out  DATA_WIDTH  received frame; valid in the done cycle, held until next done
- rsp_error_o  out  1  timeout flag; valid in the done cycle
- busy_o  out  1  high in any state other than IDLE
- eng_wren_o  out  1  one-cycle write strobe to the SPI engine
- eng_data_o  out  DATA_WIDTH  frame driven to the engine; held during the transaction
- eng_sensor_o  out  SENSOR_IDX_W  sensor index for slave-select decode; held during the transaction
- eng_do_valid_i  in  1  engine response-valid pulse
- eng_data_i  in  DATA_WIDTH  engine received data

Behaviour:
- Reset (async, any state):
  - all outputs 0; state IDLE.
  - round-robin pointer rr_ptr = 0; gap and timeout counters = 0.
  - An in-flight transaction is abandoned and no done is issued.
- States: IDLE, WAIT_RESP, GAP. All outputs registered.
- IDLE:
  - If any req_i bit is high, pick the winner: the first set bit searching from rr_ptr upward, wrapping modulo NUM_CLIENTS.
  - Next cycle: grant_o = onehot(winner), eng_wren_o = 1 (exactly one cycle), eng_data_o and eng_sensor_o = the winner's slices, rr_ptr = (winner+1) mod NUM_CLIENTS, timeout counter = 0, state WAIT_RESP.
  - Request-to-strobe latency is 1 cycle.
- WAIT_RESP:
  - Timeout counter increments every cycle.
  - On eng_do_valid_i: next cycle rsp_data_o = eng_data_i, rsp_error_o = 0, done_o[winner] = 1 for one cycle, grant_o = 0, state GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without eng_do_valid_i: same completion, but rsp_data_o = 0 and rsp_error_o = 1.
  - do_valid arriving on the timeout cycle counts as a success.
- GAP:
  - Gap counter loads GAP_CYCLES on entry and decrements; state returns to IDLE when it reaches 0.
  - GAP_CYCLES = 0: go straight from WAIT_RESP completion to IDLE.
  - Minimum spacing between eng_wren_o pulses = response latency + GAP_CYCLES + 2 cycles.
- req_i and req_data_i are sampled only in the IDLE arbitration cycle.
  - Changes while granted are ignored.
  - A client that drops req_i mid-transaction still receives its done pulse.
- eng_do_valid_i outside WAIT_RESP is ignored: no done, no state change.
- rsp_error_o clears only on the next done; rsp_data_o holds until the next done.
- Clients must hold req_i high until their done pulse and deassert it in the cycle after done to avoid re-arbitration. A client that keeps req_i high is re-served only after all other pending clients (fairness).
- NUM_CLIENTS = 1 degenerates to a fixed grant to client 0.

Test Plan:
- Single request, client 0, data 20'h2C001, sensor 2; engine returns 20'h12345 after 40 cycles -> eng_wren_o 1 cycle after req, eng_sensor_o = 2, done_o = 3'b001 one cycle after do_valid, rsp_data_o = 20'h12345, rsp_error_o = 0.
- Clients 0, 1, 2 requesting continuously, engine responding in 10 cycles -> grant order 0, 1, 2, 0, 1, ...; eng_wren_o spacing = 10 + 50 + 2 = 62 cycles.
- Engine never responds, TIMEOUT_CYCLES = 16 -> done_o pulses 16 cycles after wren with rsp_error_o = 1, rsp_data_o = 0; the next request is served after the gap.
- Spurious eng_do_valid_i in IDLE and in GAP -> no done_o, rsp_data_o unchanged.
- reset_n pulsed low in WAIT_RESP -> all outputs 0 immediately; after release, a pending client 2 request is served (rr_ptr = 0, winner 2), no stale done.
- Client 1 drops req_i one cycle after grant -> done_o[1] still pulses; client 0 req_data_i changed during WAIT_RESP -> eng_data_o unchanged.
